// File: rtl/fwd_scoreboard_if.sv
// Pipeline-side bundle for the forwarding scoreboard: EX producer info,
// load return, read-port requests and the forwarding/stall results.
interface fwd_scoreboard_if #(
  parameter int XLEN   = 32,
  parameter int NUM_RP = 2
);
  logic                     ex_wen;
  logic [4:0]               ex_rd;
  logic                     ex_ready;
  logic [XLEN-1:0]          ex_data;
  logic                     ex_flush;
  logic                     pipe_hold;
  logic                     ld_valid;
  logic [XLEN-1:0]          ld_data;
  logic [NUM_RP-1:0]        rp_en;
  logic [5*NUM_RP-1:0]      rp_addr;
  logic [NUM_RP-1:0]        fwd_hit;
  logic [XLEN*NUM_RP-1:0]   fwd_data;
  logic                     stall;
  logic [31:0]              stall_cnt;
  logic                     err;

  // Pipeline side drives requests and consumes forwarding results.
  modport master (
    output ex_wen, ex_rd, ex_ready, ex_data, ex_flush, pipe_hold,
           ld_valid, ld_data, rp_en, rp_addr,
    input  fwd_hit, fwd_data, stall, stall_cnt, err
  );

  // Scoreboard side.
  modport slave (
    input  ex_wen, ex_rd, ex_ready, ex_data, ex_flush, pipe_hold,
           ld_valid, ld_data, rp_en, rp_addr,
    output fwd_hit, fwd_data, stall, stall_cnt, err
  );
endinterface

// File: rtl/fwd_scoreboard.sv
// Post-EX forwarding scoreboard: tracks rd/data of every in-flight slot
// after EX, forwards youngest-first to NUM_RP read ports, raises load-use
// stalls, counts stall cycles and flags loads that leave without data.

// One read port: youngest (lowest index) matching slot wins.
module fwd_lookup #(
  parameter int XLEN  = 32,
  parameter int DEPTH = 2
) (
  input  logic                        en,
  input  logic [4:0]                  addr,
  input  logic [DEPTH-1:0]            vld,
  input  logic [DEPTH-1:0][4:0]       rd,
  input  logic [DEPTH-1:0]            rdy,
  input  logic [DEPTH-1:0][XLEN-1:0]  sdata,
  output logic                        hit,
  output logic                        pend,
  output logic [XLEN-1:0]             data
);
  // Scan oldest to youngest so the youngest match overwrites older ones.
  always_comb begin
    hit  = 1'b0;
    pend = 1'b0;
    data = '0;
    if (en && addr != 5'd0) begin
      for (int i = DEPTH-1; i >= 0; i--) begin
        if (vld[i] && rd[i] == addr) begin
          hit  = rdy[i];
          pend = !rdy[i];
          data = rdy[i] ? sdata[i] : '0;
        end
      end
    end
  end
endmodule

module fwd_scoreboard #(
  parameter int XLEN      = 32,
  parameter int DEPTH     = 2,
  parameter int NUM_RP    = 2,
  parameter int LOAD_SLOT = 0
) (
  input logic            clk,
  input logic            rst,
  fwd_scoreboard_if.slave bus
);
  typedef struct packed {
    logic            valid;
    logic [4:0]      rd;
    logic            ready;
    logic [XLEN-1:0] data;
  } slot_t;

  // Where a filled load lands after a shift; when the load slot is the
  // last one the entry retires and the fill simply goes with it.
  localparam int LD_DST     = (LOAD_SLOT < DEPTH-1) ? LOAD_SLOT + 1 : LOAD_SLOT;
  localparam bit LD_RETIRES = (LOAD_SLOT == DEPTH-1);

  slot_t [DEPTH-1:0]             slots, nxt;
  logic  [DEPTH-1:0]             s_vld, s_rdy;
  logic  [DEPTH-1:0][4:0]        s_rd;
  logic  [DEPTH-1:0][XLEN-1:0]   s_data;
  logic  [NUM_RP-1:0]            hit, pend;
  logic  [NUM_RP-1:0][XLEN-1:0]  fdata;
  logic                          stall;
  logic                          ld_open, fill, insert;
  slot_t                         ins;
  logic  [31:0]                  cnt;
  logic                          err;

  genvar g;
  generate
    for (g = 0; g < DEPTH; g++) begin : g_slot
      assign s_vld[g]  = slots[g].valid;
      assign s_rd[g]   = slots[g].rd;
      assign s_rdy[g]  = slots[g].ready;
      assign s_data[g] = slots[g].data;
    end
    for (g = 0; g < NUM_RP; g++) begin : g_port
      fwd_lookup #(.XLEN(XLEN), .DEPTH(DEPTH)) u_lk (
        .en    (bus.rp_en[g]),
        .addr  (bus.rp_addr[5*g +: 5]),
        .vld   (s_vld),
        .rd    (s_rd),
        .rdy   (s_rdy),
        .sdata (s_data),
        .hit   (hit[g]),
        .pend  (pend[g]),
        .data  (fdata[g])
      );
    end
  endgenerate

  assign stall   = (|pend) && !bus.ex_flush;
  assign ld_open = slots[LOAD_SLOT].valid && !slots[LOAD_SLOT].ready;
  assign fill    = bus.ld_valid && ld_open;
  assign insert  = bus.ex_wen && bus.ex_rd != 5'd0 && !stall && !bus.ex_flush;

  // New slot-0 entry; a stalled or flushed EX leaves a bubble.
  always_comb begin
    ins = '0;
    if (insert) begin
      ins.valid = 1'b1;
      ins.rd    = bus.ex_rd;
      ins.ready = bus.ex_ready;
      ins.data  = bus.ex_ready ? bus.ex_data : '0;
    end
  end

  // Next slot state: shift + insert when running, in-place fill when held.
  always_comb begin
    nxt = slots;
    if (!bus.pipe_hold) begin
      for (int i = 1; i < DEPTH; i++) nxt[i] = slots[i-1];
      nxt[0] = ins;
      if (fill && !LD_RETIRES) begin
        nxt[LD_DST].ready = 1'b1;
        nxt[LD_DST].data  = bus.ld_data;
      end
    end else if (fill) begin
      nxt[LOAD_SLOT].ready = 1'b1;
      nxt[LOAD_SLOT].data  = bus.ld_data;
    end
  end

  // Slot registers.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) slots <= '0;
    else     slots <= nxt;
  end

  // Saturating count of stall cycles that actually cost a pipeline advance.
  always_ff @(posedge clk or posedge rst) begin
    if (rst)                                          cnt <= '0;
    else if (stall && !bus.pipe_hold && cnt != '1)    cnt <= cnt + 32'd1;
  end

  // Sticky: a load moved out of its data-return slot with nothing filled.
  always_ff @(posedge clk or posedge rst) begin
    if (rst)                                          err <= 1'b0;
    else if (!bus.pipe_hold && ld_open && !bus.ld_valid) err <= 1'b1;
  end

  assign bus.fwd_hit   = hit;
  assign bus.fwd_data  = fdata;
  assign bus.stall     = stall;
  assign bus.stall_cnt = cnt;
  assign bus.err       = err;
endmodule
